// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, opcode encodings and
// saturating-counter helpers used by the branch predictor.
package mips_pkg;

   localparam int ADDR_W_DEF = 30;
   localparam int CNT_W_MAX  = 4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;

   // w is the live counter width; upper bits of c are zero
   function automatic logic [CNT_W_MAX-1:0] sat_inc(
      input logic [CNT_W_MAX-1:0] c,
      input int unsigned          w
   );
      logic [CNT_W_MAX-1:0] mx;
      mx = CNT_W_MAX'((1 << w) - 1);
      return (c >= mx) ? mx : c + 1'b1;
   endfunction

   function automatic logic [CNT_W_MAX-1:0] sat_dec(
      input logic [CNT_W_MAX-1:0] c
   );
      return (c == '0) ? '0 : c - 1'b1;
   endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// CNT_W-bit saturating up/down counter with synchronous
// load; one instance per BTB entry.
module btb_sat_counter
   import mips_pkg::*;
#(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W_MAX-1:0] wide;

   assign wide = CNT_W_MAX'(cnt);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (inc) begin
         cnt <= CNT_W'(sat_inc(wide, CNT_W));
      end else if (dec) begin
         cnt <= CNT_W'(sat_dec(wide));
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters.
// Define BTB_STATS_EN to add lookup/update/mispredict counters.
module btb_predictor
   import mips_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int ENTRIES = 16,
   parameter int CNT_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic [ADDR_W-1:0] lk_pc,
   output logic              lk_hit,
   output logic              lk_taken,
   output logic [ADDR_W-1:0] lk_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              upd_pred_taken,
   input  logic [ADDR_W-1:0] upd_pred_target,
   output logic              upd_mispredict
`ifdef BTB_STATS_EN
   ,
   output logic [31:0]       stat_lookups,
   output logic [31:0]       stat_updates,
   output logic [31:0]       stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W;

   if (ENTRIES < 2 || ENTRIES > 256 ||
       (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
      $error("btb_predictor: ENTRIES must be a power of two in 2..256");
   end
   if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt
      $error("btb_predictor: CNT_W must be in 1..4");
   end
   if (ADDR_W <= IDX_W) begin : g_bad_addr
      $error("btb_predictor: ADDR_W must exceed index width");
   end

   logic [ENTRIES-1:0] valid;
   logic [TAG_W-1:0]   tag    [ENTRIES];
   logic [ADDR_W-1:0]  target [ENTRIES];
   logic [CNT_W-1:0]   cnt    [ENTRIES];

   logic [IDX_W-1:0] li;
   logic [IDX_W-1:0] ui;
   logic [TAG_W-1:0] ut;
   logic             u_hit;
   logic             upd_en;

   assign li = lk_pc[IDX_W-1:0];
   assign ui = upd_pc[IDX_W-1:0];
   assign ut = upd_pc[ADDR_W-1:IDX_W];

   assign lk_hit    = valid[li] && (tag[li] == lk_pc[ADDR_W-1:IDX_W]);
   assign lk_taken  = lk_hit && cnt[li][CNT_W-1];
   assign lk_target = lk_hit ? target[li] : '0;

   assign u_hit  = valid[ui] && (tag[ui] == ut);
   assign upd_en = upd_valid && !flush;

   assign upd_mispredict = upd_valid &&
      ((upd_taken != upd_pred_taken) ||
       (upd_taken && (upd_target != upd_pred_target)));

   // Taken hit and taken miss both write tag/target and set valid
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         for (int e = 0; e < ENTRIES; e++) begin
            tag[e]    <= '0;
            target[e] <= '0;
         end
      end else if (flush) begin
         valid <= '0;
      end else if (upd_valid && upd_taken) begin
         valid[ui]  <= 1'b1;
         tag[ui]    <= ut;
         target[ui] <= upd_target;
      end
   end

   for (genvar e = 0; e < ENTRIES; e++) begin : g_cnt
      logic sel;
      assign sel = upd_en && (ui == IDX_W'(e));
      btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .load     (sel && !u_hit && upd_taken),
         .load_val (CNT_W'(1 << (CNT_W - 1))),
         .inc      (sel && u_hit && upd_taken),
         .dec      (sel && u_hit && !upd_taken),
         .cnt      (cnt[e])
      );
   end

`ifdef BTB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_lookups     <= '0;
         stat_updates     <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (lk_hit)         stat_lookups     <= stat_lookups + 1'b1;
         if (upd_valid)      stat_updates     <= stat_updates + 1'b1;
         if (upd_mispredict) stat_mispredicts <= stat_mispredicts + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (ENTRIES=16, CNT_W=2);
// stats checks are compiled in when BTB_STATS_EN is defined.
module tb_btb_predictor;

   localparam int AW = 30;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic [AW-1:0] lk_pc = '0;
   logic          lk_hit, lk_taken;
   logic [AW-1:0] lk_target;
   logic          upd_valid = 1'b0;
   logic [AW-1:0] upd_pc = '0;
   logic          upd_taken = 1'b0;
   logic [AW-1:0] upd_target = '0;
   logic          upd_pred_taken = 1'b0;
   logic [AW-1:0] upd_pred_target = '0;
   logic          upd_mispredict;
`ifdef BTB_STATS_EN
   logic [31:0]   stat_lookups, stat_updates, stat_mispredicts;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   btb_predictor #(.ADDR_W(AW), .ENTRIES(16), .CNT_W(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .lk_pc           (lk_pc),
      .lk_hit          (lk_hit),
      .lk_taken        (lk_taken),
      .lk_target       (lk_target),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_taken       (upd_taken),
      .upd_target      (upd_target),
      .upd_pred_taken  (upd_pred_taken),
      .upd_pred_target (upd_pred_target),
      .upd_mispredict  (upd_mispredict)
`ifdef BTB_STATS_EN
      ,
      .stat_lookups     (stat_lookups),
      .stat_updates     (stat_updates),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v, input logic [AW-1:0] pc,
                      input logic t, input logic [AW-1:0] tg,
                      input logic pt, input logic [AW-1:0] ptg);
      upd_valid       = v;
      upd_pc          = pc;
      upd_taken       = t;
      upd_target      = tg;
      upd_pred_taken  = pt;
      upd_pred_target = ptg;
      #1;
   endtask

   task automatic idle();
      drv(1'b0, '0, 1'b0, '0, 1'b0, '0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      cyc();
      rst = 1'b0;
      lk_pc = 30'h40;
      #1;
      n_checks++;
      if (lk_hit !== 1'b0) begin
         n_fail++; $display("FAIL reset_hit got %b want 0", lk_hit);
      end
      n_checks++;
      if (lk_taken !== 1'b0) begin
         n_fail++; $display("FAIL reset_taken got %b want 0", lk_taken);
      end
      n_checks++;
      if (lk_target !== 30'h0) begin
         n_fail++; $display("FAIL reset_target got %h want 0", lk_target);
      end
      n_checks++;
      if (upd_mispredict !== 1'b0) begin
         n_fail++; $display("FAIL reset_mispred got %b want 0", upd_mispredict);
      end
   endtask

   task automatic test_allocate();
      lk_pc = 30'h40;
      drv(1'b1, 30'h40, 1'b1, 30'h80, 1'b0, 30'h0);
      n_checks++;
      if (upd_mispredict !== 1'b1) begin
         n_fail++; $display("FAIL alloc_mispred got %b want 1", upd_mispredict);
      end
      cyc();
      idle();
      n_checks++;
      if ({lk_hit, lk_taken} !== 2'b11) begin
         n_fail++; $display("FAIL alloc_hit_taken got %b want 11", {lk_hit, lk_taken});
      end
      n_checks++;
      if (lk_target !== 30'h80) begin
         n_fail++; $display("FAIL alloc_target got %h want 80", lk_target);
      end
   endtask

   task automatic test_counter();
      lk_pc = 30'h40;
      // 2 -> 1, predicted taken so a direction mispredict
      drv(1'b1, 30'h40, 1'b0, 30'h0, 1'b1, 30'h80);
      n_checks++;
      if (upd_mispredict !== 1'b1) begin
         n_fail++; $display("FAIL nt_mispred got %b want 1", upd_mispredict);
      end
      cyc();
      idle();
      n_checks++;
      if ({lk_hit, lk_taken} !== 2'b10) begin
         n_fail++; $display("FAIL cnt1_hit_taken got %b want 10", {lk_hit, lk_taken});
      end
      // not taken correctly predicted: target ignored
      drv(1'b1, 30'h40, 1'b0, 30'h0, 1'b0, 30'h123);
      n_checks++;
      if (upd_mispredict !== 1'b0) begin
         n_fail++; $display("FAIL nt_ok_mispred got %b want 0", upd_mispredict);
      end
      cyc();
      cyc();
      // counter saturated at 0; one taken -> 1
      drv(1'b1, 30'h40, 1'b1, 30'h80, 1'b0, 30'h0);
      cyc();
      idle();
      n_checks++;
      if ({lk_hit, lk_taken} !== 2'b10) begin
         n_fail++; $display("FAIL cnt_sat0_hit_taken got %b want 10", {lk_hit, lk_taken});
      end
      drv(1'b1, 30'h40, 1'b1, 30'h80, 1'b1, 30'h80);
      n_checks++;
      if (upd_mispredict !== 1'b0) begin
         n_fail++; $display("FAIL t_ok_mispred got %b want 0", upd_mispredict);
      end
      cyc();
      idle();
      n_checks++;
      if (lk_taken !== 1'b1) begin
         n_fail++; $display("FAIL cnt2_taken got %b want 1", lk_taken);
      end
      // taken with wrong target: mispredict, target replaced, cnt 3
      drv(1'b1, 30'h40, 1'b1, 30'h90, 1'b1, 30'h80);
      n_checks++;
      if (upd_mispredict !== 1'b1) begin
         n_fail++; $display("FAIL tgt_mispred got %b want 1", upd_mispredict);
      end
      cyc();
      cyc();
      drv(1'b1, 30'h40, 1'b0, 30'h0, 1'b1, 30'h90);
      cyc();
      idle();
      n_checks++;
      if ({lk_hit, lk_taken} !== 2'b11) begin
         n_fail++; $display("FAIL cnt_sat3_hit_taken got %b want 11", {lk_hit, lk_taken});
      end
      n_checks++;
      if (lk_target !== 30'h90) begin
         n_fail++; $display("FAIL new_target got %h want 90", lk_target);
      end
   endtask

   task automatic test_alias();
      drv(1'b1, 30'h50, 1'b1, 30'hA0, 1'b0, 30'h0);
      cyc();
      idle();
      lk_pc = 30'h40;
      #1;
      n_checks++;
      if (lk_hit !== 1'b0) begin
         n_fail++; $display("FAIL alias_old_hit got %b want 0", lk_hit);
      end
      lk_pc = 30'h50;
      #1;
      n_checks++;
      if ({lk_hit, lk_taken, lk_target} !== {2'b11, 30'hA0}) begin
         n_fail++; $display("FAIL alias_new got %b%b %h want 11 a0", lk_hit, lk_taken, lk_target);
      end
      drv(1'b1, 30'h60, 1'b0, 30'h0, 1'b0, 30'h0);
      cyc();
      idle();
      n_checks++;
      if ({lk_hit, lk_target} !== {1'b1, 30'hA0}) begin
         n_fail++; $display("FAIL alias_nt_keep got %b %h want 1 a0", lk_hit, lk_target);
      end
      lk_pc = 30'h60;
      #1;
      n_checks++;
      if (lk_hit !== 1'b0) begin
         n_fail++; $display("FAIL alias_nt_alloc got %b want 0", lk_hit);
      end
   endtask

   task automatic test_flush();
      flush = 1'b1;
      drv(1'b1, 30'h44, 1'b1, 30'hB0, 1'b0, 30'h0);
      cyc();
      flush = 1'b0;
      idle();
      lk_pc = 30'h44;
      #1;
      n_checks++;
      if (lk_hit !== 1'b0) begin
         n_fail++; $display("FAIL flush_upd_hit got %b want 0", lk_hit);
      end
      lk_pc = 30'h50;
      #1;
      n_checks++;
      if ({lk_hit, lk_target} !== {1'b0, 30'h0}) begin
         n_fail++; $display("FAIL flush_old_hit got %b %h want 0 0", lk_hit, lk_target);
      end
   endtask

   task automatic test_same_cycle();
      lk_pc = 30'h48;
      drv(1'b1, 30'h48, 1'b1, 30'hC0, 1'b0, 30'h0);
      n_checks++;
      if (lk_hit !== 1'b0) begin
         n_fail++; $display("FAIL same_cyc_hit got %b want 0", lk_hit);
      end
      cyc();
      idle();
      n_checks++;
      if ({lk_hit, lk_target} !== {1'b1, 30'hC0}) begin
         n_fail++; $display("FAIL next_cyc_hit got %b %h want 1 c0", lk_hit, lk_target);
      end
   endtask

   task automatic test_rst_override();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      lk_pc = 30'h4C;
      drv(1'b1, 30'h4C, 1'b1, 30'hD0, 1'b0, 30'h0);
      cyc();
      idle();
      n_checks++;
      if (lk_hit !== 1'b1) begin
         n_fail++; $display("FAIL pre_rst_hit got %b want 1", lk_hit);
      end
      cyc();
`ifdef BTB_STATS_EN
      n_checks++;
      if ({stat_lookups, stat_updates, stat_mispredicts} !== {32'd1, 32'd1, 32'd1}) begin
         n_fail++;
         $display("FAIL stats_count got %0d %0d %0d want 1 1 1",
                  stat_lookups, stat_updates, stat_mispredicts);
      end
`endif
      rst = 1'b1;
      drv(1'b1, 30'h58, 1'b1, 30'hE0, 1'b0, 30'h0);
      cyc();
      rst = 1'b0;
      idle();
      n_checks++;
      if (lk_hit !== 1'b0) begin
         n_fail++; $display("FAIL rst_clear_hit got %b want 0", lk_hit);
      end
      lk_pc = 30'h58;
      #1;
      n_checks++;
      if (lk_hit !== 1'b0) begin
         n_fail++; $display("FAIL rst_over_upd got %b want 0", lk_hit);
      end
`ifdef BTB_STATS_EN
      n_checks++;
      if ({stat_lookups, stat_updates, stat_mispredicts} !== 96'h0) begin
         n_fail++;
         $display("FAIL stats_rst got %0d %0d %0d want 0 0 0",
                  stat_lookups, stat_updates, stat_mispredicts);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_counter();
      test_alias();
      test_flush();
      test_same_cycle();
      test_rst_override();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
